// File: rtl/pe_drain_pkg.sv
// rtl/pe_drain_pkg.sv - shared types, default widths and priority encoder for the PE result drain
package pe_drain_pkg;

    localparam int DRAIN_D_WIDTH      = 64;
    localparam int DRAIN_A_PART_WIDTH = 1;
    localparam int DRAIN_B_NUM_WIDTH  = 1;
    localparam int DRAIN_PE_NUM_WIDTH = 2;
    localparam int DRAIN_ADDR_WIDTH   = DRAIN_A_PART_WIDTH + DRAIN_B_NUM_WIDTH;
    localparam int DRAIN_PE_NUM       = 1 << DRAIN_PE_NUM_WIDTH;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_READ  = 2'd1,
        ST_FLUSH = 2'd2
    } drain_state_t;

    typedef struct packed {
        logic [DRAIN_D_WIDTH-1:0]      data;
        logic [DRAIN_PE_NUM_WIDTH-1:0] pid;
        logic [DRAIN_ADDR_WIDTH-1:0]   addr;
        logic                          last;
    } drain_entry_t;

    // Fixed priority: PID 0 wins.
    function automatic logic [DRAIN_PE_NUM_WIDTH-1:0] lowest_set(input logic [DRAIN_PE_NUM-1:0] v);
        lowest_set = '0;
        for (int i = DRAIN_PE_NUM - 1; i >= 0; i--) begin
            if (v[i]) begin
                lowest_set = DRAIN_PE_NUM_WIDTH'(i);
            end
        end
    endfunction

endpackage

// File: rtl/drain_skid_buf.sv
// rtl/drain_skid_buf.sv - two-entry valid/ready result buffer with occupancy for credit accounting
module drain_skid_buf
    import pe_drain_pkg::*;
(
    input  logic         clk,
    input  logic         rst,
    input  logic         push_valid,
    input  drain_entry_t push_entry,
    output logic         pop_valid,
    input  logic         pop_ready,
    output drain_entry_t pop_entry,
    output logic [1:0]   occupancy
);

    drain_entry_t mem [2];
    logic         rd_ptr;
    logic         wr_ptr;
    logic [1:0]   count;
    logic         do_push;
    logic         do_pop;

    // The drain's credit check guarantees a push never arrives when full.
    always_comb begin
        do_pop  = pop_ready && (count != 2'd0);
        do_push = push_valid && (count != 2'd2);
    end

    // Storage, pointers and occupancy; storage is cleared so outputs read 0 after reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 2; i++) begin
                mem[i] <= '0;
            end
            rd_ptr <= 1'b0;
            wr_ptr <= 1'b0;
            count  <= 2'd0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= push_entry;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            count <= count + 2'(do_push) - 2'(do_pop);
        end
    end

    assign pop_valid = (count != 2'd0);
    assign pop_entry = mem[rd_ptr];
    assign occupancy = count;

endmodule

// File: rtl/pe_result_drain.sv
// rtl/pe_result_drain.sv - drains finished PE result tiles onto one stream; PE_DRAIN_OVERRUN_EN adds overrun_out
module pe_result_drain
    import pe_drain_pkg::*;
#(
    parameter int D_WIDTH      = DRAIN_D_WIDTH,
    parameter int A_PART_WIDTH = DRAIN_A_PART_WIDTH,
    parameter int B_NUM_WIDTH  = DRAIN_B_NUM_WIDTH,
    parameter int PE_NUM_WIDTH = DRAIN_PE_NUM_WIDTH,
    parameter int PE_NUM       = 1 << PE_NUM_WIDTH
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [PE_NUM-1:0]                   trigger_in,
    output logic [PE_NUM-1:0]                   res_rd_en_out,
    output logic [A_PART_WIDTH+B_NUM_WIDTH-1:0] res_rd_addr_out,
    input  logic [PE_NUM*D_WIDTH-1:0]           res_rd_data_in,
    output logic [D_WIDTH-1:0]                  res_data_out,
    output logic [PE_NUM_WIDTH-1:0]             res_pid_out,
    output logic [A_PART_WIDTH+B_NUM_WIDTH-1:0] res_addr_out,
    output logic                                res_last_out,
    output logic                                res_valid_out,
    input  logic                                res_ready_in,
    output logic                                busy_out
`ifdef PE_DRAIN_OVERRUN_EN
    ,
    output logic                                overrun_out
`endif
);

    localparam int ADDR_W = A_PART_WIDTH + B_NUM_WIDTH;
    localparam logic [ADDR_W-1:0] ADDR_LAST = '1;

    drain_state_t             state_q;
    logic [PE_NUM-1:0]        trig_q;
    logic [PE_NUM-1:0]        pending_q;
    logic [PE_NUM_WIDTH-1:0]  sel_q;
    logic [ADDR_W-1:0]        addr_q;
    logic                     inflight_q;
    logic [ADDR_W-1:0]        inflight_addr_q;

    logic [PE_NUM-1:0]        rise;
    logic [PE_NUM-1:0]        cand;
    logic [PE_NUM-1:0]        clear_mask;
    logic                     pick;
    logic [PE_NUM_WIDTH-1:0]  pick_sel;
    logic                     pop;
    logic [2:0]               load;
    logic                     issue;
    logic [1:0]               occ;
    logic                     buf_valid;
    drain_entry_t             push_entry;
    drain_entry_t             head;

    // Edge detect, arbitration and credit check. New edges join the candidates in the same
    // cycle so a trigger reaches the read port one cycle later. The credit counts a word
    // leaving the buffer this cycle, which keeps one word per cycle under full ready.
    always_comb begin
        rise       = trigger_in & ~trig_q;
        cand       = pending_q | rise;
        pick       = (state_q == ST_IDLE) && (cand != '0);
        pick_sel   = lowest_set(cand);
        clear_mask = pick ? (PE_NUM'(1) << pick_sel) : '0;
        pop        = buf_valid && res_ready_in;
        load       = 3'(occ) + 3'(inflight_q) - 3'(pop);
        issue      = (state_q == ST_READ) && (load < 3'd2);
    end

    // Drain FSM, pending set, address counter and the one-deep in-flight tracker.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q         <= ST_IDLE;
            trig_q          <= '0;
            pending_q       <= '0;
            sel_q           <= '0;
            addr_q          <= '0;
            inflight_q      <= 1'b0;
            inflight_addr_q <= '0;
        end else begin
            trig_q     <= trigger_in;
            pending_q  <= cand & ~clear_mask;
            inflight_q <= issue;
            if (issue) begin
                inflight_addr_q <= addr_q;
            end
            case (state_q)
                ST_IDLE: begin
                    if (pick) begin
                        sel_q   <= pick_sel;
                        addr_q  <= '0;
                        state_q <= ST_READ;
                    end
                end
                ST_READ: begin
                    if (issue) begin
                        addr_q <= addr_q + 1'b1;
                        if (addr_q == ADDR_LAST) begin
                            state_q <= ST_FLUSH;
                        end
                    end
                end
                ST_FLUSH: begin
                    // The last read lands this cycle; the PE may be switched afterwards.
                    if (inflight_q) begin
                        state_q <= ST_IDLE;
                    end
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Returning read data, tagged with its source PE and word index.
    always_comb begin
        push_entry      = '0;
        push_entry.data = res_rd_data_in[sel_q*D_WIDTH +: D_WIDTH];
        push_entry.pid  = sel_q;
        push_entry.addr = inflight_addr_q;
        push_entry.last = (inflight_addr_q == ADDR_LAST);
    end

    drain_skid_buf u_buf (
        .clk        (clk),
        .rst        (rst),
        .push_valid (inflight_q),
        .push_entry (push_entry),
        .pop_valid  (buf_valid),
        .pop_ready  (res_ready_in),
        .pop_entry  (head),
        .occupancy  (occ)
    );

    assign res_rd_en_out   = issue ? (PE_NUM'(1) << sel_q) : '0;
    assign res_rd_addr_out = addr_q;
    assign res_data_out    = head.data;
    assign res_pid_out     = head.pid;
    assign res_addr_out    = head.addr;
    assign res_last_out    = head.last;
    assign res_valid_out   = buf_valid;
    assign busy_out        = (pending_q != '0) || (state_q != ST_IDLE) || (occ != 2'd0);

`ifdef PE_DRAIN_OVERRUN_EN
    logic overrun_q;

    // Sticky flag for a trigger edge landing on an already-pending PE.
    always_ff @(posedge clk) begin
        if (rst) begin
            overrun_q <= 1'b0;
        end else if ((rise & pending_q) != '0) begin
            overrun_q <= 1'b1;
        end
    end

    assign overrun_out = overrun_q;
`endif

endmodule

// File: tb/tb_pe_result_drain.sv
// tb/tb_pe_result_drain.sv - self-checking bench for pe_result_drain against a tile-queue reference model
module tb_pe_result_drain;

    localparam int D   = 64;
    localparam int AW  = 2;
    localparam int PW  = 2;
    localparam int NPE = 4;
    localparam int W   = 1 << AW;

    typedef struct {
        logic [D-1:0]  data;
        logic [PW-1:0] pid;
        logic [AW-1:0] addr;
        logic          last;
    } exp_t;

    logic                 clk;
    logic                 rst;
    logic [NPE-1:0]       trig;
    logic [NPE-1:0]       res_rd_en_out;
    logic [AW-1:0]        res_rd_addr_out;
    logic [NPE*D-1:0]     rd_data;
    logic [D-1:0]         res_data_out;
    logic [PW-1:0]        res_pid_out;
    logic [AW-1:0]        res_addr_out;
    logic                 res_last_out;
    logic                 res_valid_out;
    logic                 ready;
    logic                 busy_out;
`ifdef PE_DRAIN_OVERRUN_EN
    logic                 overrun_out;
`endif

    logic [D-1:0] base [NPE];
    exp_t         exp_q [$];
    int           checks;
    int           failures;
    bit           prev_stall;
    logic [D-1:0] prev_data;
    logic [PW-1:0] prev_pid;
    logic [AW-1:0] prev_addr;
    logic         prev_last;

    pe_result_drain dut (
        .clk             (clk),
        .rst             (rst),
        .trigger_in      (trig),
        .res_rd_en_out   (res_rd_en_out),
        .res_rd_addr_out (res_rd_addr_out),
        .res_rd_data_in  (rd_data),
        .res_data_out    (res_data_out),
        .res_pid_out     (res_pid_out),
        .res_addr_out    (res_addr_out),
        .res_last_out    (res_last_out),
        .res_valid_out   (res_valid_out),
        .res_ready_in    (ready),
        .busy_out        (busy_out)
`ifdef PE_DRAIN_OVERRUN_EN
        ,
        .overrun_out     (overrun_out)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // PE result buffers: registered read port, word = per-PE base + address.
    always @(posedge clk) begin
        for (int i = 0; i < NPE; i++) begin
            if (res_rd_en_out[i]) begin
                rd_data[i*D +: D] <= base[i] + D'(res_rd_addr_out);
            end
        end
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference model: a finished tile is W words from base[pid] upward, last on the final one.
    task automatic push_tile(input int pid);
        exp_t e;
        for (int a = 0; a < W; a++) begin
            e.data = base[pid] + D'(a);
            e.pid  = PW'(pid);
            e.addr = AW'(a);
            e.last = (a == W - 1);
            exp_q.push_back(e);
        end
    endtask

    task automatic check_outputs();
        exp_t e;
        chk("rd_en_onehot", 64'($onehot0(res_rd_en_out)), 64'd1);
        if (prev_stall) begin
            chk("stall_valid", 64'(res_valid_out), 64'd1);
            chk("stall_data", res_data_out, prev_data);
            chk("stall_pid", 64'(res_pid_out), 64'(prev_pid));
            chk("stall_addr", 64'(res_addr_out), 64'(prev_addr));
            chk("stall_last", 64'(res_last_out), 64'(prev_last));
        end
        if (res_valid_out && ready) begin
            chk("word_expected", 64'(exp_q.size() != 0), 64'd1);
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("word_data", res_data_out, e.data);
                chk("word_pid", 64'(res_pid_out), 64'(e.pid));
                chk("word_addr", 64'(res_addr_out), 64'(e.addr));
                chk("word_last", 64'(res_last_out), 64'(e.last));
            end
        end
        prev_stall = res_valid_out && !ready;
        prev_data  = res_data_out;
        prev_pid   = res_pid_out;
        prev_addr  = res_addr_out;
        prev_last  = res_last_out;
    endtask

    task automatic sample();
        @(negedge clk);
        check_outputs();
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    task automatic cycle();
        sample();
        advance();
    endtask

    task automatic do_reset();
        rst   = 1'b1;
        trig  = '0;
        ready = 1'b0;
        advance();
        advance();
        rst        = 1'b0;
        prev_stall = 1'b0;
        exp_q.delete();
    endtask

    task automatic drain(input bit rand_ready, input int budget);
        int n;
        n    = 0;
        trig = '0;
        while ((exp_q.size() != 0 || busy_out) && n < budget) begin
            ready = rand_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            cycle();
            n++;
        end
        chk("drain_left", 64'(exp_q.size()), 64'd0);
        chk("drain_busy", 64'(busy_out), 64'd0);
        ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            cycle();
        end
        chk("no_extra_words", 64'(exp_q.size()), 64'd0);
    endtask

    initial begin
        logic [NPE-1:0] mask;
        int             hold;
        checks   = 0;
        failures = 0;
        rd_data  = '0;
        for (int i = 0; i < NPE; i++) begin
            base[i] = 64'h1000_0000 * (i + 1);
        end
        do_reset();

        // Reset state
        chk("rst_rd_en", 64'(res_rd_en_out), 64'd0);
        chk("rst_valid", 64'(res_valid_out), 64'd0);
        chk("rst_data", res_data_out, 64'd0);
        chk("rst_pid", 64'(res_pid_out), 64'd0);
        chk("rst_addr", 64'(res_addr_out), 64'd0);
        chk("rst_last", 64'(res_last_out), 64'd0);
        chk("rst_busy", 64'(busy_out), 64'd0);
`ifdef PE_DRAIN_OVERRUN_EN
        chk("rst_overrun", 64'(overrun_out), 64'd0);
`endif

        // Single tile from PE2 with exact cycle timing
        base[2] = 64'h100;
        push_tile(2);
        for (int c = 0; c < 9; c++) begin
            trig  = (c == 0) ? 4'b0100 : 4'b0000;
            ready = 1'b1;
            sample();
            if (c == 1) begin
                chk("t1_rd_en", 64'(res_rd_en_out), 64'b0100);
                chk("t1_rd_addr", 64'(res_rd_addr_out), 64'd0);
            end
            if (c == 2) begin
                chk("t1_valid_c2", 64'(res_valid_out), 64'd0);
            end
            if (c >= 3 && c <= 6) begin
                chk("t1_valid", 64'(res_valid_out), 64'd1);
                chk("t1_data", res_data_out, 64'h100 + 64'(c - 3));
                chk("t1_pid", 64'(res_pid_out), 64'd2);
                chk("t1_last", 64'(res_last_out), 64'(c == 6));
            end
            if (c == 7) begin
                chk("t1_busy_c7", 64'(busy_out), 64'd0);
                chk("t1_valid_c7", 64'(res_valid_out), 64'd0);
            end
            advance();
        end
        chk("t1_all_words", 64'(exp_q.size()), 64'd0);

        // Simultaneous triggers: PE1 tile then PE3 tile
        base[1] = 64'hAAAA_0000;
        base[3] = 64'hCCCC_0000;
        push_tile(1);
        push_tile(3);
        trig  = 4'b1010;
        ready = 1'b1;
        cycle();
        drain(1'b0, 200);

        // Held-high trigger counts once
        base[1] = 64'h5151_0000;
        push_tile(1);
        trig = 4'b0010;
        for (int k = 0; k < 10; k++) begin
            cycle();
        end
        drain(1'b0, 200);

        // Re-trigger of the PE being drained queues a second drain
        base[0] = 64'h0E0E_0000;
        push_tile(0);
        push_tile(0);
        for (int c = 0; c < 5; c++) begin
            trig = (c == 0 || c == 3) ? 4'b0001 : 4'b0000;
            cycle();
        end
        drain(1'b0, 200);

        // Randomized trigger masks and hold lengths under random backpressure
        for (int r = 0; r < 8; r++) begin
            mask = NPE'($urandom_range(1, (1 << NPE) - 1));
            hold = $urandom_range(1, 3);
            for (int i = 0; i < NPE; i++) begin
                base[i] = {$urandom, $urandom};
            end
            for (int i = 0; i < NPE; i++) begin
                if (mask[i]) begin
                    push_tile(i);
                end
            end
            trig = mask;
            for (int k = 0; k < hold; k++) begin
                ready = 1'($urandom_range(0, 1));
                cycle();
            end
            drain(1'b1, 600);
        end

        // Reset in the middle of a drain abandons the tile
        base[0] = 64'h0DEA_D000;
        push_tile(0);
        for (int c = 0; c < 5; c++) begin
            trig  = (c == 0) ? 4'b0001 : 4'b0000;
            ready = 1'b1;
            rst   = (c == 4);
            cycle();
        end
        rst = 1'b0;
        exp_q.delete();
        prev_stall = 1'b0;
        chk("mid_rst_rd_en", 64'(res_rd_en_out), 64'd0);
        chk("mid_rst_valid", 64'(res_valid_out), 64'd0);
        chk("mid_rst_data", res_data_out, 64'd0);
        chk("mid_rst_pid", 64'(res_pid_out), 64'd0);
        chk("mid_rst_addr", 64'(res_addr_out), 64'd0);
        chk("mid_rst_last", 64'(res_last_out), 64'd0);
        chk("mid_rst_busy", 64'(busy_out), 64'd0);
        for (int k = 0; k < 8; k++) begin
            sample();
            chk("post_rst_no_read", 64'(res_rd_en_out), 64'd0);
            chk("post_rst_no_valid", 64'(res_valid_out), 64'd0);
            advance();
        end

`ifdef PE_DRAIN_OVERRUN_EN
        // Duplicate trigger on a pending PE sets the sticky overrun flag
        base[1] = 64'h0B0B_0000;
        base[0] = 64'h0A0A_0000;
        push_tile(1);
        push_tile(0);
        for (int c = 0; c < 5; c++) begin
            case (c)
                0:       trig = 4'b0010;
                1, 3:    trig = 4'b0001;
                default: trig = 4'b0000;
            endcase
            cycle();
        end
        chk("overrun_set", 64'(overrun_out), 64'd1);
        drain(1'b0, 200);
        chk("overrun_sticky", 64'(overrun_out), 64'd1);
        do_reset();
        chk("overrun_cleared", 64'(overrun_out), 64'd0);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
